// File: rtl/time_set_controller_pkg.sv
// Shared state encodings and defaults for the clock front-panel controller.
package time_set_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  localparam int DEFAULT_DEBOUNCE  = 500000;
  localparam int DEFAULT_TIMEOUT_S = 10;

  // Button slots in the conditioned press vector.
  localparam int NUM_BTN  = 3;
  localparam int BTN_MODE = 0;
  localparam int BTN_UP   = 1;
  localparam int BTN_DOWN = 2;

endpackage

// File: rtl/time_set_controller_button_conditioner.sv
// One push-button: 2-FF synchronizer, debounce counter, rising-edge press pulse.
module button_conditioner
  import time_set_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2;
  logic          r_stable, r_stable_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      // Any return to agreement restarts the count, so short glitches never land.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/time_set_controller.sv
// Time-set front panel: conditions mode/up/down buttons and runs the RUN/SET_HR/SET_MIN FSM
// with an idle timeout that drops back to RUN.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int TIMEOUT_S       = DEFAULT_TIMEOUT_S
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_mode,
  input  logic btn_up,
  input  logic btn_down,
  input  logic tick_1hz,
  output logic run_en,
  output logic sel_hour,
  output logic sel_min,
  output logic inc_hour,
  output logic dec_hour,
  output logic inc_min,
  output logic dec_min,
  output logic timeout_evt
);

  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_press;

  assign w_raw = {btn_down, btn_up, btn_mode};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(w_raw[g]),
      .press  (w_press[g])
    );
  end

  logic w_mode, w_up, w_dn, w_up_only, w_dn_only;

  assign w_mode    = w_press[BTN_MODE];
  assign w_up      = w_press[BTN_UP];
  assign w_dn      = w_press[BTN_DOWN];
  assign w_up_only = w_up & ~w_dn;
  assign w_dn_only = w_dn & ~w_up;

  state_t        r_state;
  logic [IW-1:0] r_idle;
  logic          r_inc_hour, r_dec_hour, r_inc_min, r_dec_min, r_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_idle     <= '0;
      r_inc_hour <= 1'b0;
      r_dec_hour <= 1'b0;
      r_inc_min  <= 1'b0;
      r_dec_min  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_inc_hour <= 1'b0;
      r_dec_hour <= 1'b0;
      r_inc_min  <= 1'b0;
      r_dec_min  <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_idle <= '0;
          if (w_mode) r_state <= ST_SET_HR;
        end
        ST_SET_HR, ST_SET_MIN: begin
          // Priority: mode, then up/down (which also restarts idle), then timeout tick.
          if (w_mode) begin
            r_state <= (r_state == ST_SET_HR) ? ST_SET_MIN : ST_RUN;
            r_idle  <= '0;
          end else if (w_up | w_dn) begin
            r_idle <= '0;
            if (r_state == ST_SET_HR) begin
              r_inc_hour <= w_up_only;
              r_dec_hour <= w_dn_only;
            end else begin
              r_inc_min <= w_up_only;
              r_dec_min <= w_dn_only;
            end
          end else if (tick_1hz) begin
            if (r_idle == IDLE_LAST) begin
              r_state   <= ST_RUN;
              r_timeout <= 1'b1;
              r_idle    <= '0;
            end else begin
              r_idle <= r_idle + IW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_idle  <= '0;
        end
      endcase
    end
  end

  assign run_en      = (r_state == ST_RUN);
  assign sel_hour    = (r_state == ST_SET_HR);
  assign sel_min     = (r_state == ST_SET_MIN);
  assign inc_hour    = r_inc_hour;
  assign dec_hour    = r_dec_hour;
  assign inc_min     = r_inc_min;
  assign dec_min     = r_dec_min;
  assign timeout_evt = r_timeout;

endmodule
